seg_scroll_animator: RTL and testbench

Parametrised multi-digit successor to the single-digit 7-segment animator. Raw 7-segment characters enter through a valid/ready port into a small FIFO. Each character scrolls in from the right, with its segments drawn one at a time on an animation tick, and is then held. The block time-multiplexes the NUM_DIGITS digit registers onto one segment bus with a one-hot digit select, ready for the top-level pin map.

---
 rtl/seg_anim_pkg.sv | 39 +++
 rtl/seg_char_fifo.sv | 78 +++++++
 rtl/seg_scroll_animator.sv | 221 ++++++++++++++++++++++
 tb/tb_seg_scroll_animator.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_anim_pkg.sv
// Shared types and constants for the scrolling 7-segment animator.
// Segment bit order is a..g on bits 0..6, with 1 meaning lit.
package seg_anim_pkg;

    // Animation controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        HOLD  = 2'd2
    } anim_state_t;

    // Segment bit positions inside a character
    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_t;

    localparam int         SEG_COUNT = 7;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // The reveal ends on the tick that exposes the last segment
    localparam logic [2:0] LAST_STEP = SEG_G;

    // Mask exposing segments a..(a+step); equal to (2 << step) - 1
    function automatic logic [SEG_COUNT-1:0] sweep_mask(input logic [2:0] step);
        logic [SEG_COUNT-1:0] mask;
        mask = SEG_BLANK;
        for (int b = 0; b < SEG_COUNT; b++) begin
            mask[b] = (b <= int'(step));
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_char_fifo.sv
// Character FIFO for the scroll animator. Power-of-two depth, registered
// occupancy count, combinational head read so the controller can shift
// the popped character into the display on the same tick edge.
// Pushes against a full FIFO are dropped and latch a sticky overflow flag.
module seg_char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_req,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             overflow_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count_reg == CNT_FULL);
    assign empty     = (count_reg == '0);
    assign push_ok   = push_req && !full;
    assign pop_ok    = pop_req && !empty;
    assign head_data = mem_reg[rd_ptr_reg];
    assign overflow  = overflow_reg;

    // Occupancy: simultaneous push and pop leave the count unchanged
    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Pointers, count and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            if (push_req && full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Storage array; contents need no reset since reads are gated by count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/seg_scroll_animator.sv
// Multi-digit scrolling 7-segment animator.
// Characters from the FIFO scroll in at digit 0 on an animation tick; the
// digit registers are scanned onto a shared segment bus with a one-hot
// digit select.
// Build option: define SEG_SCROLL_SWEEP_EN to reveal each new character one
// segment per tick (BUILD state). Without it the character appears whole
// on the pop tick and goes straight to HOLD.
module seg_scroll_animator
    import seg_anim_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 200000,
    parameter int HOLD_TICKS = 2,
    parameter int MUX_DIV    = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  char_valid,
    input  logic [6:0]            char_data,
    output logic                  char_ready,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  busy,
    output logic                  overflow
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [TICK_W-1:0]     TICK_LAST    = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0]     SCAN_LAST    = SCAN_W'(MUX_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST     = IDX_W'(NUM_DIGITS - 1);
    localparam logic [HOLD_W-1:0]     HOLD_LAST    = HOLD_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT_BASE = NUM_DIGITS'(1);

    // FIFO interface
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [SEG_COUNT-1:0] fifo_head;

    // Tick divider
    logic [TICK_W-1:0] tick_cnt_reg;
    logic              tick;

    // Controller
    anim_state_t       state_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
`ifdef SEG_SCROLL_SWEEP_EN
    logic [SEG_COUNT-1:0] cur_reg;
    logic [2:0]           step_reg;
`endif

    // Digit shift register
    logic [SEG_COUNT-1:0] digit_reg  [NUM_DIGITS];
    logic [SEG_COUNT-1:0] digit_next [NUM_DIGITS];
    logic                 digit_shift;
    logic                 digit0_we;
    logic [SEG_COUNT-1:0] digit0_val;

    // Scan mux
    logic [SCAN_W-1:0]     scan_cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [SEG_COUNT-1:0]  seg_out_reg;
    logic [NUM_DIGITS-1:0] dig_sel_reg;

    seg_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SEG_COUNT)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_req  (char_valid),
        .push_data (char_data),
        .pop_req   (digit_shift),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign char_ready = !fifo_full;
    assign busy       = (state_reg != IDLE) || !fifo_empty;
    assign seg_out    = seg_out_reg;
    assign dig_sel    = dig_sel_reg;

    // One-cycle tick at the last count of each divider period
    assign tick = ena && (tick_cnt_reg == TICK_LAST);

    // A character is popped and the display scrolls on an idle tick
    assign digit_shift = tick && (state_reg == IDLE) && !fifo_empty;

    // Tick divider: counts only while enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_reg <= '0;
        end else if (ena) begin
            if (tick_cnt_reg == TICK_LAST) begin
                tick_cnt_reg <= '0;
            end else begin
                tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
        end
    end

    // Animation FSM: pop, optional segment reveal, then hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
`ifdef SEG_SCROLL_SWEEP_EN
            cur_reg      <= SEG_BLANK;
            step_reg     <= '0;
`endif
        end else if (tick) begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
`ifdef SEG_SCROLL_SWEEP_EN
                        cur_reg   <= fifo_head;
                        step_reg  <= '0;
                        state_reg <= BUILD;
`else
                        hold_cnt_reg <= '0;
                        state_reg    <= (HOLD_TICKS == 0) ? IDLE : HOLD;
`endif
                    end
                end
`ifdef SEG_SCROLL_SWEEP_EN
                BUILD: begin
                    step_reg <= step_reg + 3'd1;
                    if (step_reg == LAST_STEP) begin
                        hold_cnt_reg <= '0;
                        state_reg    <= (HOLD_TICKS == 0) ? IDLE : HOLD;
                    end
                end
`endif
                HOLD: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Digit 0 write source: blank on a scroll, then the partial reveal
    always_comb begin
        digit0_we  = digit_shift;
        digit0_val = SEG_BLANK;
`ifdef SEG_SCROLL_SWEEP_EN
        if (tick && (state_reg == BUILD)) begin
            digit0_we  = 1'b1;
            digit0_val = cur_reg & sweep_mask(step_reg);
        end
`else
        digit0_val = fifo_head;
`endif
    end

    // Next value per digit: digit 0 takes new data, others take their neighbour
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_head
                assign digit_next[gi] = digit0_we ? digit0_val : digit_reg[gi];
            end else begin : g_tail
                assign digit_next[gi] = digit_shift ? digit_reg[gi-1] : digit_reg[gi];
            end
        end
    endgenerate

    // Digit registers; the oldest character falls off the top digit
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!rst_n) begin
                digit_reg[i] <= SEG_BLANK;
            end else begin
                digit_reg[i] <= digit_next[i];
            end
        end
    end

    // Scan divider and digit index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_reg <= '0;
            idx_reg      <= '0;
        end else if (ena) begin
            if (scan_cnt_reg == SCAN_LAST) begin
                scan_cnt_reg <= '0;
                idx_reg      <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
            end
        end
    end

    // Registered scan outputs; display is dark while frozen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_out_reg <= SEG_BLANK;
            dig_sel_reg <= '0;
        end else if (ena) begin
            seg_out_reg <= digit_reg[idx_reg];
            dig_sel_reg <= ONE_HOT_BASE << idx_reg;
        end else begin
            seg_out_reg <= SEG_BLANK;
            dig_sel_reg <= '0;
        end
    end

endmodule

// File: tb/tb_seg_scroll_animator.sv
// Directed bench for seg_scroll_animator (4 digits, 4-deep FIFO, tick every
// 4 clocks, 1 hold tick, scan step every 2 clocks). Expectations follow the
// SEG_SCROLL_SWEEP_EN build option.
module tb_seg_scroll_animator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       char_valid;
    logic [6:0] char_data;
    logic       char_ready;
    logic [6:0] seg_out;
    logic [3:0] dig_sel;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [6:0] sweep_exp [7]  = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h3F};
    logic [6:0] final_digit [4] = '{7'h6D, 7'h66, 7'h4F, 7'h5B};
    logic [6:0] freeze_exp;

    seg_scroll_animator #(
        .NUM_DIGITS (4),
        .FIFO_DEPTH (4),
        .TICK_DIV   (4),
        .HOLD_TICKS (1),
        .MUX_DIV    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_raw(input logic [6:0] val);
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = val;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        $display("push 0x%02h ready_after=%0d overflow=%0d", val, char_ready, overflow);
    endtask

    task automatic push_char(input logic [6:0] val);
        bit got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (char_ready) got = 1'b1;
        end
        if (got) begin
            char_valid = 1'b1;
            char_data  = val;
            @(posedge clk);
            #1;
            char_valid = 1'b0;
            $display("push 0x%02h accepted", val);
        end else begin
            check("push_ready_timeout", 32'(got), 32'd1);
        end
    endtask

    task automatic wait_tick(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (dut.tick) seen = 1'b1;
        end
        if (seen) begin
            @(posedge clk);
            #1;
            $display("tick %s d0=0x%02h busy=%0d", tag, dut.digit_reg[0], busy);
        end else begin
            check({tag, "_tick_timeout"}, 32'(seen), 32'd1);
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        bit idle = 1'b0;
        for (int i = 0; i < limit && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        check({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] prev_sel;
        bit         found;

        // Reset with stimulus active
        rst_n      = 1'b0;
        ena        = 1'b1;
        char_valid = 1'b1;
        char_data  = 7'h55;
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg_out",    32'(seg_out),    32'h00);
        check("rst_dig_sel",    32'(dig_sel),    32'h0);
        check("rst_char_ready", 32'(char_ready), 32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        @(negedge clk);
        char_valid = 1'b0;
        rst_n      = 1'b1;

        // Single character: reveal then hold
        push_char(7'h3F);
        wait_tick("pop1");
        check("pop1_busy", 32'(busy), 32'd1);
`ifdef SEG_SCROLL_SWEEP_EN
        check("pop1_d0", 32'(dut.digit_reg[0]), 32'h00);
        for (int k = 0; k < 7; k++) begin
            wait_tick("build");
            check($sformatf("sweep_d0_step%0d", k), 32'(dut.digit_reg[0]), 32'(sweep_exp[k]));
        end
        check("sweep_busy_in_hold", 32'(busy), 32'd1);
        wait_tick("hold");
`else
        check("pop1_d0", 32'(dut.digit_reg[0]), 32'h3F);
        wait_tick("hold");
`endif
        check("sweep_done_busy", 32'(busy), 32'd0);
        check("sweep_done_d0",   32'(dut.digit_reg[0]), 32'h3F);

        // Freeze mid-animation
        push_char(7'h7F);
        wait_tick("pop2");
        check("pop2_d1", 32'(dut.digit_reg[1]), 32'h3F);
`ifdef SEG_SCROLL_SWEEP_EN
        repeat (3) wait_tick("build");
        freeze_exp = 7'h07;
`else
        freeze_exp = 7'h7F;
`endif
        check("freeze_pre_d0", 32'(dut.digit_reg[0]), 32'(freeze_exp));
        ena = 1'b0;
        @(posedge clk);
        #1;
        check("freeze_seg_out", 32'(seg_out), 32'h00);
        check("freeze_dig_sel", 32'(dig_sel), 32'h0);
        repeat (9) @(posedge clk);
        #1;
        check("freeze_d0",        32'(dut.digit_reg[0]), 32'(freeze_exp));
        check("freeze_busy",      32'(busy),    32'd1);
        check("freeze_seg_out_2", 32'(seg_out), 32'h00);
        check("freeze_dig_sel_2", 32'(dig_sel), 32'h0);
        ena = 1'b1;
        wait_tick("resume");
`ifdef SEG_SCROLL_SWEEP_EN
        check("resume_d0", 32'(dut.digit_reg[0]), 32'h0F);
`else
        check("resume_busy", 32'(busy), 32'd0);
`endif
        wait_idle("freeze", 500);

        // Overflow with animation frozen
        @(negedge clk);
        ena = 1'b0;
        push_raw(7'h06);
        push_raw(7'h5B);
        push_raw(7'h4F);
        push_raw(7'h66);
        check("full_char_ready",   32'(char_ready), 32'd0);
        check("full_busy",         32'(busy),       32'd1);
        check("full_overflow_pre", 32'(overflow),   32'd0);
        push_raw(7'h6D);
        check("ovf_overflow",   32'(overflow),   32'd1);
        check("ovf_char_ready", 32'(char_ready), 32'd0);

        // Scroll the queued characters plus the re-sent one
        ena = 1'b1;
        push_char(7'h6D);
        wait_idle("scroll", 3000);
        check("scroll_overflow_sticky", 32'(overflow), 32'd1);

        // Scan sequence: each digit shown for two cycles with its pattern
        found    = 1'b0;
        prev_sel = dig_sel;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dig_sel == 4'b0001 && prev_sel != 4'b0001) found = 1'b1;
            else prev_sel = dig_sel;
        end
        check("scan_sync", 32'(found), 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            $display("scan k=%0d dig_sel=%b seg_out=0x%02h", k, dig_sel, seg_out);
            check($sformatf("scan_sel_%0d", k), 32'(dig_sel), 32'(4'b0001 << (k / 2)));
            check($sformatf("scan_seg_%0d", k), 32'(seg_out), 32'(final_digit[k / 2]));
        end
        @(negedge clk);
        check("scan_wrap_sel", 32'(dig_sel), 32'h1);

        // Reset in the middle of an animation
        push_char(7'h5B);
        wait_tick("pop3");
`ifdef SEG_SCROLL_SWEEP_EN
        wait_tick("build");
        wait_tick("build");
`endif
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("midrst_d%0d", i), 32'(dut.digit_reg[i]), 32'h00);
        end
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_seg_out",  32'(seg_out),  32'h00);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
